perf_pipe_counter: RTL and testbench

PERF_PIPE_COUNTER -- requirements
Module: perf_pipe_counter

---
 rtl/perf_pipe_counter.sv | 195 +++++++++++++++++++
 tb/tb_perf_pipe_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/perf_pipe_counter.sv
// perf_pipe_counter: per-stage pipeline occupancy counters (run / stall / bubble)
// plus a global cycle counter. All counters saturate at all-ones. A snap pulse
// copies the live set into a shadow set, and reads are always served from the
// shadow set so that software sees one consistent snapshot.
module perf_pipe_counter #(
  parameter int NUM_STAGES = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_STAGES-1:0] stage_valid,
  input  logic [NUM_STAGES-1:0] stage_stall,
  input  logic                  clear,
  input  logic                  snap,
  input  logic                  rd_req,
  input  logic [7:0]            rd_id,
  input  logic [1:0]            rd_sel,
  output logic                  rd_ack,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_err
);

  localparam logic [7:0]           GLOBAL_ID = 8'hFF;
  localparam logic [7:0]           STAGES_B  = 8'(NUM_STAGES);
  localparam int                   IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Shadow values of every stage, gathered for the read multiplexer.
  logic [NUM_STAGES-1:0][CNT_WIDTH-1:0] run_sh;
  logic [NUM_STAGES-1:0][CNT_WIDTH-1:0] stall_sh;
  logic [NUM_STAGES-1:0][CNT_WIDTH-1:0] bub_sh;

  // ---------------------------------------------------------------------------
  // Per-stage live and shadow counters
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      logic [CNT_WIDTH-1:0] run_q,    run_d;
      logic [CNT_WIDTH-1:0] stall_q,  stall_d;
      logic [CNT_WIDTH-1:0] bub_q,    bub_d;
      logic [CNT_WIDTH-1:0] run_sh_q, run_sh_d;
      logic [CNT_WIDTH-1:0] stall_sh_q, stall_sh_d;
      logic [CNT_WIDTH-1:0] bub_sh_q, bub_sh_d;

      // Next live values: clear wins over counting; exactly one of the three
      // counters advances per enabled cycle, chosen by the stage's state.
      always_comb begin
        run_d   = run_q;
        stall_d = stall_q;
        bub_d   = bub_q;
        if (clear) begin
          run_d   = CNT_ZERO;
          stall_d = CNT_ZERO;
          bub_d   = CNT_ZERO;
        end else if (en) begin
          if (!stage_valid[gi]) begin
            bub_d = sat_inc(bub_q);
          end else if (stage_stall[gi]) begin
            stall_d = sat_inc(stall_q);
          end else begin
            run_d = sat_inc(run_q);
          end
        end
      end

      // Next shadow values: snap captures the live values as they stand before
      // this edge's update, so coincident clear/count never leak into the copy.
      always_comb begin
        run_sh_d   = run_sh_q;
        stall_sh_d = stall_sh_q;
        bub_sh_d   = bub_sh_q;
        if (snap) begin
          run_sh_d   = run_q;
          stall_sh_d = stall_q;
          bub_sh_d   = bub_q;
        end
      end

      // Live and shadow registers for this stage.
      always_ff @(posedge clk) begin
        if (!rst) begin
          run_q      <= CNT_ZERO;
          stall_q    <= CNT_ZERO;
          bub_q      <= CNT_ZERO;
          run_sh_q   <= CNT_ZERO;
          stall_sh_q <= CNT_ZERO;
          bub_sh_q   <= CNT_ZERO;
        end else begin
          run_q      <= run_d;
          stall_q    <= stall_d;
          bub_q      <= bub_d;
          run_sh_q   <= run_sh_d;
          stall_sh_q <= stall_sh_d;
          bub_sh_q   <= bub_sh_d;
        end
      end

      assign run_sh[gi]   = run_sh_q;
      assign stall_sh[gi] = stall_sh_q;
      assign bub_sh[gi]   = bub_sh_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Global cycle counter
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] glob_q,    glob_d;
  logic [CNT_WIDTH-1:0] glob_sh_q, glob_sh_d;

  // Next global live/shadow values, same clear/snap rules as the stage counters.
  always_comb begin
    glob_d    = glob_q;
    glob_sh_d = glob_sh_q;
    if (clear) begin
      glob_d = CNT_ZERO;
    end else if (en) begin
      glob_d = sat_inc(glob_q);
    end
    if (snap) begin
      glob_sh_d = glob_q;
    end
  end

  // Global live and shadow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      glob_q    <= CNT_ZERO;
      glob_sh_q <= CNT_ZERO;
    end else begin
      glob_q    <= glob_d;
      glob_sh_q <= glob_sh_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: one request per cycle, response one cycle later
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_ack_q,  rd_ack_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_err_q,  rd_err_d;

  assign rd_idx = rd_id[IDX_W-1:0];

  // Decode the request against the shadow set as it stands before this edge,
  // so a read coinciding with snap returns the previous snapshot.
  always_comb begin
    rd_ack_d  = 1'b0;
    rd_data_d = CNT_ZERO;
    rd_err_d  = 1'b0;
    if (rd_req) begin
      rd_ack_d = 1'b1;
      if (rd_id == GLOBAL_ID) begin
        rd_data_d = glob_sh_q;
      end else if (rd_id >= STAGES_B) begin
        rd_err_d = 1'b1;
      end else begin
        case (rd_sel)
          2'd0:    rd_data_d = run_sh[rd_idx];
          2'd1:    rd_data_d = stall_sh[rd_idx];
          2'd2:    rd_data_d = bub_sh[rd_idx];
          default: rd_err_d  = 1'b1;
        endcase
      end
    end
  end

  // Registered read response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= CNT_ZERO;
      rd_err_q  <= 1'b0;
    end else begin
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
    end
  end

  // A response already registered when reset arrives is suppressed, so no
  // acknowledge is ever seen once reset has been applied.
  assign rd_ack  = rd_ack_q & rst;
  assign rd_data = rst ? rd_data_q : CNT_ZERO;
  assign rd_err  = rd_err_q & rst;

endmodule

// File: tb/tb_perf_pipe_counter.sv
// tb_perf_pipe_counter: directed scenarios plus randomized traffic against a
// behavioural model built from plain integer arrays.
module tb_perf_pipe_counter;
  localparam int NS   = 8;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, clear = 1'b0, snap = 1'b0, rd_req = 1'b0;
  logic [NS-1:0] stage_valid = '0, stage_stall = '0;
  logic [7:0]    rd_id = '0;
  logic [1:0]    rd_sel = '0;
  logic          rd_ack, rd_err;
  logic [W-1:0]  rd_data;

  always #5 clk = ~clk;

  perf_pipe_counter #(.NUM_STAGES(NS), .CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .stage_valid(stage_valid), .stage_stall(stage_stall),
    .clear(clear), .snap(snap),
    .rd_req(rd_req), .rd_id(rd_id), .rd_sel(rd_sel),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: index 0 = run, 1 = stall, 2 = bubble.
  int live [3][NS];
  int shad [3][NS];
  int glob = 0, glob_sh = 0;
  bit exp_ack = 0, exp_err = 0;
  int exp_data = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NS; i++) begin
        live[k][i] = 0;
        shad[k][i] = 0;
      end
    glob = 0;
    glob_sh = 0;
  endtask

  // One clock cycle: apply inputs, check the response due now, advance model.
  task automatic step(input bit r, input bit e, input bit c, input bit s, input bit q,
                      input logic [NS-1:0] v, input logic [NS-1:0] st,
                      input logic [7:0] id, input logic [1:0] sel);
    bit ack_now;
    @(negedge clk);
    rst = r; en = e; clear = c; snap = s; rd_req = q;
    stage_valid = v; stage_stall = st; rd_id = id; rd_sel = sel;
    #1;
    ack_now = exp_ack && r;
    check_val("rd_ack", 64'(rd_ack), 64'(ack_now));
    check_val("rd_data", 64'(rd_data), ack_now ? 64'(exp_data) : 64'd0);
    check_val("rd_err", 64'(rd_err), 64'(ack_now && exp_err));
    if (ack_now) $display("read response data=%0d err=%0d", rd_data, rd_err);
    if (!r) begin
      model_reset();
      exp_ack = 0; exp_err = 0; exp_data = 0;
    end else begin
      exp_ack = q; exp_err = 0; exp_data = 0;
      if (q) begin
        if (id == 8'hFF) exp_data = glob_sh;
        else if (int'(id) >= NS || sel == 2'd3) exp_err = 1;
        else exp_data = shad[int'(sel)][int'(id)];
      end
      if (s) begin
        for (int k = 0; k < 3; k++)
          for (int i = 0; i < NS; i++) shad[k][i] = live[k][i];
        glob_sh = glob;
      end
      if (c) begin
        for (int k = 0; k < 3; k++)
          for (int i = 0; i < NS; i++) live[k][i] = 0;
        glob = 0;
      end else if (e) begin
        for (int i = 0; i < NS; i++) begin
          int kind;
          kind = !v[i] ? 2 : (st[i] ? 1 : 0);
          if (live[kind][i] < MAXV) live[kind][i]++;
        end
        if (glob < MAXV) glob++;
      end
    end
  endtask

  task automatic idle(input int n, input bit e, input logic [NS-1:0] v, input logic [NS-1:0] st);
    for (int j = 0; j < n; j++) step(1, e, 0, 0, 0, v, st, 8'd0, 2'd0);
  endtask

  task automatic rd(input logic [7:0] id, input logic [1:0] sel);
    step(1, 1, 0, 0, 1, '0, '0, id, sel);
  endtask

  initial begin
    model_reset();
    // Reset state
    for (int j = 0; j < 3; j++) step(0, 1, 0, 0, 1, '1, '0, 8'hFF, 2'd0);

    // Stage 2 run 5, stall 3, bubble 2, then snap and read back
    idle(5, 1, 8'h04, 8'h00);
    idle(3, 1, 8'h04, 8'h04);
    idle(2, 1, 8'h00, 8'h00);
    step(1, 1, 0, 1, 0, '0, '0, 8'd0, 2'd0);
    rd(8'd2, 2'd0); rd(8'd2, 2'd1); rd(8'd2, 2'd2); rd(8'hFF, 2'd3);
    // Invalid reads back to back
    rd(8'd8, 2'd0); rd(8'd2, 2'd3); rd(8'd0, 2'd0);

    // Saturation: 300 valid cycles on every stage
    step(1, 1, 1, 0, 0, '0, '0, 8'd0, 2'd0);
    idle(300, 1, '1, '0);
    step(1, 1, 0, 1, 0, '1, '0, 8'd0, 2'd0);
    rd(8'd0, 2'd0); rd(8'hFF, 2'd0); rd(8'd0, 2'd0);

    // Snap together with clear
    step(1, 1, 1, 0, 0, '0, '0, 8'd0, 2'd0);
    idle(10, 1, 8'h0F, 8'h03);
    step(1, 1, 1, 1, 0, '0, '0, 8'd0, 2'd0);
    rd(8'hFF, 2'd0);
    idle(3, 1, 8'h0F, 8'h03);
    step(1, 1, 0, 1, 1, '0, '0, 8'hFF, 2'd0);   // read coinciding with snap
    rd(8'hFF, 2'd0); rd(8'd1, 2'd1);

    // Enable low window amid activity
    idle(4, 1, 8'hA5, 8'h21);
    idle(6, 0, 8'h5A, 8'h12);
    idle(2, 1, 8'hA5, 8'h21);
    step(1, 1, 0, 1, 0, '0, '0, 8'd0, 2'd0);
    rd(8'hFF, 2'd0); rd(8'd0, 2'd0); rd(8'd1, 2'd2); rd(8'd5, 2'd1);

    // Reset directly after a read request
    rd(8'hFF, 2'd0);
    step(0, 1, 1, 1, 1, '1, '0, 8'hFF, 2'd0);
    step(1, 1, 0, 1, 0, '0, '0, 8'd0, 2'd0);
    rd(8'hFF, 2'd0); rd(8'd3, 2'd0); rd(8'd7, 2'd2);

    // Randomized traffic
    for (int j = 0; j < 1500; j++) begin
      bit r, e, c, s, q;
      logic [7:0] id;
      int pick;
      r = ($urandom_range(0, 149) != 0);
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 7) == 0);
      q = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 11);
      id = (pick >= 10) ? 8'hFF : 8'(pick);
      step(r, e, c, s, q, NS'($urandom), NS'($urandom), id, 2'($urandom));
    end
    idle(2, 0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
